adc_scan_sequencer: RTL and testbench

//  Multi-channel scan controller for the SPI ADC capture engine (adc_capture).

---
 rtl/adc_scan_sequencer.sv | 165 ++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// Round-robin scan controller for the SPI ADC capture engine.
// Averages 2**AVG_LOG2 conversions per channel into a result bank.
module adc_scan_sequencer #(
   parameter int AVG_LOG2       = 2,
   parameter int SETTLE_CYCLES  = 30,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  chan_mask,
   input  logic        err_clr,
   input  logic        adc_ready,
   input  logic [11:0] adc_data,
   output logic        adc_start,
   output logic [2:0]  adc_addr,
   output logic        sample_valid,
   output logic [2:0]  sample_chan,
   output logic [11:0] sample_data,
   output logic        scan_done,
   input  logic [2:0]  rd_chan,
   output logic [11:0] rd_data,
   output logic        timeout_err
);

   localparam int AW = 12 + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam int WW = $clog2(TIMEOUT_CYCLES);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(1 << AVG_LOG2);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      PICK,
      START,
      WAIT,
      SETTLE
   } state_t;

   state_t state, state_nxt;

   logic [2:0]    cur_chan;
   logic [2:0]    pick_chan;
   logic [7:0]    scan_mask;
   logic [AW-1:0] acc;
   logic [AW-1:0] acc_sum;
   logic [11:0]   avg;
   logic [CW-1:0] conv_cnt;
   logic [WW-1:0] wait_cnt;
   logic [SW-1:0] settle_cnt;
   logic [11:0]   bank [8];
   logic          pick_ok;
   logic          conv_ok;
   logic          timeout;
   logic          visit_done;
   logic          last_chan;
   logic          settle_end;

   // Lowest iteration wins, so the search starts just after cur_chan.
   // i=8 wraps back onto cur_chan for a single-bit mask.
   always_comb begin
      pick_chan = cur_chan;
      for (int i = 8; i >= 1; i--) begin
         if (chan_mask[cur_chan + 3'(i)]) begin
            pick_chan = cur_chan + 3'(i);
         end
      end
   end

   assign pick_ok    = en && (chan_mask != 8'd0);
   assign conv_ok    = (state == WAIT) && adc_ready;
   assign timeout    = (state == WAIT) && !adc_ready && (wait_cnt == WAIT_LAST);
   assign visit_done = (conv_cnt == CNT_LAST);
   assign acc_sum    = acc + AW'(adc_data);
   assign avg        = acc_sum[AVG_LOG2 +: 12];
   assign last_chan  = (scan_mask >> cur_chan) <= 8'd1;
   assign settle_end = (settle_cnt == SETTLE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      adc_start = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_ok) state_nxt = PICK;
         end
         PICK: begin
            state_nxt = pick_ok ? START : IDLE;
         end
         START: begin
            adc_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (conv_ok) state_nxt = SETTLE;
            else if (timeout) state_nxt = PICK;
         end
         SETTLE: begin
            if (settle_end) begin
               state_nxt = (conv_cnt == CNT_FULL) ? PICK : START;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_chan     <= 3'd7;
         adc_addr     <= 3'd0;
         scan_mask    <= 8'd0;
         acc          <= '0;
         conv_cnt     <= '0;
         wait_cnt     <= '0;
         settle_cnt   <= '0;
         sample_valid <= 1'b0;
         sample_chan  <= 3'd0;
         sample_data  <= 12'd0;
         scan_done    <= 1'b0;
         timeout_err  <= 1'b0;
         rd_data      <= 12'd0;
         for (int i = 0; i < 8; i++) bank[i] <= 12'd0;
      end else begin
         sample_valid <= 1'b0;
         scan_done    <= 1'b0;
         rd_data      <= bank[rd_chan];
         if (timeout) timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
         if (state == PICK && pick_ok) begin
            cur_chan  <= pick_chan;
            adc_addr  <= pick_chan;
            scan_mask <= chan_mask;
            acc       <= '0;
            conv_cnt  <= '0;
         end
         if (state == START) wait_cnt <= '0;
         if (state == WAIT) wait_cnt <= wait_cnt + WW'(1);
         if (conv_ok) begin
            acc        <= acc_sum;
            conv_cnt   <= conv_cnt + CW'(1);
            settle_cnt <= '0;
            // Result lands during the first SETTLE cycle of the last conversion.
            if (visit_done) begin
               bank[cur_chan] <= avg;
               sample_valid   <= 1'b1;
               sample_chan    <= cur_chan;
               sample_data    <= avg;
               scan_done      <= last_chan;
            end
         end
         if (state == SETTLE) settle_cnt <= settle_cnt + SW'(1);
      end
   end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Randomized bench for adc_scan_sequencer with a channel/average
// reference model driven by a behavioural ADC responder.
module tb_adc_scan_sequencer;

   localparam int AVG    = 2;
   localparam int NAVG   = 1 << AVG;
   localparam int SETTLE = 30;
   localparam int TMO    = 4096;

   logic        clk;
   logic        rst;
   logic        en;
   logic [7:0]  chan_mask;
   logic        err_clr;
   logic        adc_ready;
   logic [11:0] adc_data;
   logic        adc_start;
   logic [2:0]  adc_addr;
   logic        sample_valid;
   logic [2:0]  sample_chan;
   logic [11:0] sample_data;
   logic        scan_done;
   logic [2:0]  rd_chan;
   logic [11:0] rd_data;
   logic        timeout_err;

   adc_scan_sequencer #(
      .AVG_LOG2(AVG),
      .SETTLE_CYCLES(SETTLE),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .chan_mask(chan_mask),
      .err_clr(err_clr),
      .adc_ready(adc_ready),
      .adc_data(adc_data),
      .adc_start(adc_start),
      .adc_addr(adc_addr),
      .sample_valid(sample_valid),
      .sample_chan(sample_chan),
      .sample_data(sample_data),
      .scan_done(scan_done),
      .rd_chan(rd_chan),
      .rd_data(rd_data),
      .timeout_err(timeout_err)
   );

   typedef struct {
      int chan;
      int data;
      int last;
   } exp_t;

   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   int   starts_seen = 0;
   int   samples_seen = 0;
   int   dones = 0;
   int   starts_at [8];
   int   exp_bank [8];
   exp_t exp_q [$];
   int   fd_q [$];
   bit   suppress = 0;
   int   prev_chan = 7;
   int   conv_in_visit = 0;
   int   visit_chan = 0;
   logic [7:0] visit_mask = 8'd0;
   int   sum = 0;
   int   last_lat = 0;
   int   last_start_cyc = 0;
   int   last_sdata = 0;
   int   last_schan = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string tag, int got, int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int next_chan(int prev, logic [7:0] m);
      for (int i = 1; i <= 8; i++) begin
         if (m[(prev + i) % 8]) return (prev + i) % 8;
      end
      return -1;
   endfunction

   task automatic model_reset();
      prev_chan = 7;
      conv_in_visit = 0;
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_bank[i] = 0;
   endtask

   // ADC responder and conversion-order model
   initial begin
      int a, lat, d;
      exp_t e;
      adc_ready = 1'b0;
      adc_data = 12'd0;
      for (int i = 0; i < 8; i++) starts_at[i] = 0;
      forever begin
         @(negedge clk);
         if (!rst && adc_start) begin
            a = int'(adc_addr);
            starts_seen++;
            starts_at[a]++;
            if (conv_in_visit == 0) begin
               check("visit_chan", a, next_chan(prev_chan, chan_mask));
               visit_chan = a;
               visit_mask = chan_mask;
               prev_chan = a;
               sum = 0;
            end else begin
               check("addr_hold", a, visit_chan);
               check("spacing", cyc - last_start_cyc, last_lat + SETTLE + 1);
            end
            last_start_cyc = cyc;
            if (suppress) begin
               conv_in_visit = 0;
            end else begin
               lat = $urandom_range(1, 8);
               d = (fd_q.size() > 0) ? fd_q.pop_front() : $urandom_range(0, 4095);
               last_lat = lat;
               repeat (lat) @(negedge clk);
               adc_ready = 1'b1;
               adc_data = 12'(d);
               sum += d;
               conv_in_visit++;
               if (conv_in_visit == NAVG) begin
                  e.chan = a;
                  e.data = sum / NAVG;
                  e.last = ((visit_mask >> (a + 1)) == 8'd0) ? 1 : 0;
                  exp_q.push_back(e);
                  conv_in_visit = 0;
               end
               @(negedge clk);
               adc_ready = 1'b0;
               adc_data = 12'($urandom_range(0, 4095));
            end
         end
      end
   end

   // Result monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (scan_done) dones++;
            if (sample_valid) begin
               samples_seen++;
               last_sdata = int'(sample_data);
               last_schan = int'(sample_chan);
               if (exp_q.size() == 0) begin
                  check("sample_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("sample_chan", int'(sample_chan), e.chan);
                  check("sample_data", int'(sample_data), e.data);
                  check("scan_done", int'(scan_done), e.last);
                  exp_bank[e.chan] = e.data;
               end
            end else if (scan_done) begin
               check("scan_done_alone", 1, 0);
            end
         end
      end
   end

   task automatic wait_samples(int target, int budget, string tag);
      int n = 0;
      while (samples_seen < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, int'(samples_seen >= target), 1);
   endtask

   task automatic wait_starts(int target, int budget, string tag);
      int n = 0;
      while (starts_seen < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, int'(starts_seen >= target), 1);
   endtask

   task automatic check_bank(string tag);
      for (int i = 0; i < 8; i++) begin
         rd_chan = 3'(i);
         @(negedge clk);
         check(tag, int'(rd_data), exp_bank[i]);
      end
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_start"}, int'(adc_start), 0);
      check({tag, "_addr"}, int'(adc_addr), 0);
      check({tag, "_valid"}, int'(sample_valid), 0);
      check({tag, "_schan"}, int'(sample_chan), 0);
      check({tag, "_sdata"}, int'(sample_data), 0);
      check({tag, "_done"}, int'(scan_done), 0);
      check({tag, "_err"}, int'(timeout_err), 0);
      check({tag, "_rd"}, int'(rd_data), 0);
   endtask

   initial begin
      int s0, d0, sc, smp, n, b1;
      rst = 1'b1;
      en = 1'b0;
      chan_mask = 8'd0;
      err_clr = 1'b0;
      rd_chan = 3'd0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Fixed data on ch0, then ch2 expected next
      fd_q = '{100, 200, 300, 400};
      chan_mask = 8'h05;
      en = 1'b1;
      wait_samples(1, 1000, "t1_sample");
      check("t1_avg", last_sdata, 250);
      check("t1_chan", last_schan, 0);
      s0 = starts_seen;
      wait_starts(s0 + 1, 200, "t1_next_start");
      check("t1_next_addr", int'(adc_addr), 2);
      wait_samples(samples_seen + 3, 3000, "t1_more");
      en = 1'b0;
      repeat (300) @(negedge clk);

      // Random masks, random visit counts
      for (int r = 0; r < 4; r++) begin
         chan_mask = 8'($urandom_range(1, 255));
         en = 1'b1;
         wait_samples(samples_seen + $urandom_range(1, 4), 3000, "rnd_samples");
         en = 1'b0;
         repeat (300) @(negedge clk);
      end
      check_bank("rnd_bank");

      // Single channel 7
      chan_mask = 8'h80;
      s0 = starts_seen;
      d0 = dones;
      smp = samples_seen;
      en = 1'b1;
      wait_samples(smp + 3, 3000, "t2_samples");
      check("t2_starts", starts_seen - s0, 3 * NAVG);
      check("t2_done", dones - d0, 3);
      check("t2_addr", int'(adc_addr), 7);
      en = 1'b0;
      repeat (300) @(negedge clk);

      // en dropped during second conversion of ch3
      chan_mask = 8'h08;
      s0 = starts_seen;
      smp = samples_seen;
      en = 1'b1;
      wait_starts(s0 + 2, 300, "t4_second");
      en = 1'b0;
      repeat (400) @(negedge clk);
      check("t4_samples", samples_seen - smp, 1);
      check("t4_starts", starts_seen - s0, NAVG);
      check("t4_chan", last_schan, 3);

      // Mask change mid-visit of ch0
      chan_mask = 8'h03;
      en = 1'b1;
      n = 0;
      while (!(adc_start && adc_addr == 3'd0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("t6_ch0_start", int'(adc_start && adc_addr == 3'd0), 1);
      @(negedge clk);
      chan_mask = 8'h0C;
      b1 = starts_at[1];
      n = 0;
      while (!(adc_start && adc_addr != 3'd0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("t6_next", int'(adc_addr), 2);
      en = 1'b0;
      repeat (300) @(negedge clk);
      check("t6_ch1", starts_at[1] - b1, 0);
      check_bank("t6_bank");

      // Timeouts, err_clr, and err_clr colliding with a timeout
      suppress = 1'b1;
      chan_mask = 8'h06;
      s0 = starts_seen;
      smp = samples_seen;
      en = 1'b1;
      wait_starts(s0 + 1, 100, "t3_start");
      sc = last_start_cyc;
      n = 0;
      while (!timeout_err && n < TMO + 200) begin
         @(negedge clk);
         n++;
      end
      check("t3_delay", cyc - sc, TMO + 1);
      check("t3_no_sample", samples_seen - smp, 0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("t3_clr", int'(timeout_err), 0);
      wait_starts(s0 + 2, 100, "t3_restart");
      sc = last_start_cyc;
      n = 0;
      while (cyc < sc + TMO && n < TMO + 200) begin
         @(negedge clk);
         n++;
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      en = 1'b0;
      check("t3_err_wins", int'(timeout_err), 1);
      repeat (50) @(negedge clk);
      check("t3_idle", starts_seen - s0, 2);
      suppress = 1'b0;

      // Reset while in WAIT
      suppress = 1'b1;
      chan_mask = 8'h24;
      s0 = starts_seen;
      en = 1'b1;
      wait_starts(s0 + 1, 100, "t5_start");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      en = 1'b0;
      @(negedge clk);
      check_all_zero("t5");
      rst = 1'b0;
      model_reset();
      suppress = 1'b0;
      check_bank("t5_bank");

      // Post-reset scan restarts from ch0
      chan_mask = 8'h05;
      en = 1'b1;
      wait_samples(samples_seen + 2, 2000, "post_samples");
      en = 1'b0;
      repeat (300) @(negedge clk);
      check_bank("post_bank");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
